display_scan_mux: RTL and testbench

Time-multiplexed driver for a parametrised number of common-anode 7-segment digits, all sharing one segment bus. It latches a packed hex value and scans the digits at a programmable rate. Each digit slot starts with anti-ghosting guard cycles, and leading zeros can be blanked. The block sits between the datapath result registers and the board display pins, and replaces the per-digit combinational decoder instances.

---
 rtl/display_pkg.sv | 35 +++
 rtl/hex_seg_decoder.sv | 13 +
 rtl/display_scan_mux.sv | 141 ++++++++++++++
 tb/tb_display_scan_mux.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared 7-segment display constants and hex glyph table.
// Latency: none (constants and a pure function).
// Backpressure: none; consumers are free-running display drivers.
package display_pkg;

    // All segments dark (segments are active low).
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Hex nibble to active-low segment pattern, bit order {a,b,c,d,e,f,g} on [6:0].
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] pattern;
        pattern = SEG_BLANK;
        case (nibble)
            4'h0: pattern = 7'b0000001;
            4'h1: pattern = 7'b1001111;
            4'h2: pattern = 7'b0010010;
            4'h3: pattern = 7'b0000110;
            4'h4: pattern = 7'b1001100;
            4'h5: pattern = 7'b0100100;
            4'h6: pattern = 7'b0100000;
            4'h7: pattern = 7'b0001111;
            4'h8: pattern = 7'b0000000;
            4'h9: pattern = 7'b0000100;
            4'hA: pattern = 7'b0001000;
            4'hB: pattern = 7'b1100000;
            4'hC: pattern = 7'b0110001;
            4'hD: pattern = 7'b1000010;
            4'hE: pattern = 7'b0110000;
            4'hF: pattern = 7'b0111000;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/hex_seg_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows input every cycle.
module hex_seg_decoder
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver with guard cycles and leading-zero blanking.
// Latency: outputs registered, one cycle behind the (cnt, digit) scan state; new value shown from next frame.
// Backpressure: none; load is always accepted, last load before a frame boundary wins.
module display_scan_mux
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int GUARD      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DATA_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
    localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(NUM_DIGITS - 1);

    // Scan position
    logic [CNT_W-1:0]      cnt;
    logic [DIG_W-1:0]      digit;

    // Pending (most recent load) and active (currently displayed) frame contents
    logic [DATA_W-1:0]     pend_val;
    logic [NUM_DIGITS-1:0] pend_dp;
    logic [DATA_W-1:0]     act_val;
    logic [NUM_DIGITS-1:0] act_dp;

    // Decode path
    logic                  slot_end;
    logic                  frame_end;
    logic                  lit;
    logic [NUM_DIGITS-1:0] blank_mask;
    logic [NUM_DIGITS-1:0] an_next;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [6:0]            dec_seg;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (digit == DIG_LAST);
    // Guard cycles at the start of each slot keep all anodes off to hide ghosting.
    assign lit       = (cnt >= CNT_GUARD);

    // Slot counter and digit pointer; digit wraps after the last digit (frame boundary).
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            digit <= '0;
        end else if (slot_end) begin
            cnt   <= '0;
            digit <= (digit == DIG_LAST) ? '0 : digit + 1'b1;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

    // Pending captures every load; active only swaps at a frame boundary, with a load on that cycle bypassing pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_val <= '0;
            pend_dp  <= '0;
            act_val  <= '0;
            act_dp   <= '0;
        end else begin
            if (load) begin
                pend_val <= value;
                pend_dp  <= dp_in;
            end
            if (frame_end) begin
                act_val <= load ? value : pend_val;
                act_dp  <= load ? dp_in : pend_dp;
            end
        end
    end

    // Leading-zero mask: a digit blanks when it and every more-significant nibble are zero; digit 0 always shows.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        blank_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero    = upper_zero && (act_val[4*i +: 4] == 4'h0);
            blank_mask[i] = blank_lz && upper_zero && (i != 0);
        end
    end

    // Select the current digit's nibble, decimal point and blank flag, and build the anode pattern.
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        an_next   = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit == DIG_W'(i)) begin
                cur_nib    = act_val[4*i +: 4];
                cur_dp     = act_dp[i];
                cur_blank  = blank_mask[i];
                an_next[i] = ~lit;
            end
        end
    end

    hex_seg_decoder u_dec (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    // Register the pins; outside the lit window everything is dark, a blanked digit keeps its anode and dp.
    always_ff @(posedge clk) begin
        if (rst) begin
            an         <= '1;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an         <= an_next;
            frame_done <= frame_end;
            if (lit) begin
                seg <= cur_blank ? SEG_BLANK : dec_seg;
                dp  <= ~cur_dp;
            end else begin
                seg <= SEG_BLANK;
                dp  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
module tb_display_scan_mux;

    localparam int ND    = 4;
    localparam int DIV   = 8;
    localparam int GRD   = 2;
    localparam int FRAME = ND * DIV;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   value;
    logic [3:0]    dp_in;
    logic          load;
    logic          blank_lz;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dp;
    logic          frame_done;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: time since reset and the frame contents
    int          s;
    logic [15:0] m_pend_v, m_act_v;
    logic [3:0]  m_pend_dp, m_act_dp;

    logic [6:0] seg_tab [16];

    display_scan_mux #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (DIV),
        .GUARD      (GRD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp_in      (dp_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, s, obs, exp);
        end
    endtask

    // One clock: predict outputs from the model, advance model, then compare away from the edge.
    task automatic tick();
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp, e_fd;
        logic [3:0]  nib;
        int          p, d, c;
        @(posedge clk);
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
        if (rst) begin
            s = 0;
            m_pend_v = '0; m_pend_dp = '0; m_act_v = '0; m_act_dp = '0;
        end else begin
            p = s % FRAME;
            d = p / DIV;
            c = p % DIV;
            e_fd = (p == FRAME - 1);
            if (c >= GRD) begin
                e_an[d] = 1'b0;
                nib = 4'((m_act_v >> (4 * d)) & 16'hF);
                if (blank_lz && d != 0 && (m_act_v >> (4 * d)) == 16'h0)
                    e_seg = 7'h7F;
                else
                    e_seg = seg_tab[nib];
                e_dp = ~m_act_dp[d];
            end
            if (p == FRAME - 1) begin
                m_act_v  = load ? value : m_pend_v;
                m_act_dp = load ? dp_in : m_pend_dp;
            end
            if (load) begin
                m_pend_v  = value;
                m_pend_dp = dp_in;
            end
            s++;
        end
        #1;
        chk("an", 32'(an), 32'(e_an));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("dp", 32'(dp), 32'(e_dp));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
        chk("an_onehot", 32'($countones(~an) <= 1), 32'(1));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic run_to(input int pos);
        for (int k = 0; k < 2 * FRAME && (s % FRAME) != pos; k++) tick();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v; dp_in = d; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    initial begin
        seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        s = 0;
        m_pend_v = '0; m_pend_dp = '0; m_act_v = '0; m_act_dp = '0;
        rst = 1'b1; value = 16'h0; dp_in = 4'h0; load = 1'b0; blank_lz = 1'b0;

        // Reset, then release with nothing loaded
        run(2);
        rst = 1'b0;
        run(2 * FRAME);

        // Plain hex with a decimal point on digit 2
        do_load(16'h12EF, 4'b0100);
        run(2 * FRAME + 5);

        // Leading-zero blanking, then an all-zero value
        blank_lz = 1'b1;
        do_load(16'h0050, 4'b0000);
        run(2 * FRAME);
        do_load(16'h0000, 4'b0100);
        run(2 * FRAME);

        // Back-to-back loads mid-frame; the last one wins at the boundary
        run_to(10);
        do_load(16'hAAAA, 4'b0001);
        do_load(16'hBBBB, 4'b0010);
        run(2 * FRAME);

        // Load on the boundary cycle bypasses pending
        run_to(FRAME - 1);
        do_load(16'hCCCC, 4'b1000);
        run(FRAME + 3);

        // Reset at digit 2, cnt 5 with a simultaneous load that must be discarded
        run_to(2 * DIV + 5);
        rst = 1'b1; value = 16'h9876; load = 1'b1;
        tick();
        rst = 1'b0; load = 1'b0;
        run(2 * FRAME);

        // Randomized loads, blanking and occasional reset
        for (int k = 0; k < 1500; k++) begin
            load     = ($urandom_range(0, 7) == 0);
            value    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            dp_in    = 4'($urandom);
            blank_lz = ($urandom_range(0, 3) != 0);
            rst      = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0; load = 1'b0;
        run(FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
